// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
//
// Sits between the core load/store port and main data memory. Load hits are
// served combinationally; a load miss refills the whole line word by word;
// every store is forwarded to memory. The core holds its inputs while stall=1.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en       load / store request (store wins when both are set)
//   addr, wdata        byte address (addr[1:0] ignored), store data
//   rdata, stall       load data (0 on miss), core hold request
//   mem_req, mem_we    memory request valid, 1 = write / 0 = read
//   mem_addr           word-aligned memory byte address
//   mem_wdata          memory write data
//   mem_rdata          memory read data, valid with mem_ready
//   mem_ready          memory accepts/completes the current request
module data_cache #(
   parameter int WD    = 32,
   parameter int SETS  = 16,
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en,
   input  logic          wr_en,
   input  logic [WD-1:0] addr,
   input  logic [WD-1:0] wdata,
   output logic [WD-1:0] rdata,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [WD-1:0] mem_addr,
   output logic [WD-1:0] mem_wdata,
   input  logic [WD-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = WD - OFF_W - IDX_W - 2;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

   state_t state, state_nx;

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tag_arr  [SETS];
   logic [WD-1:0]    data_arr [SETS][WORDS];

   logic [OFF_W-1:0] cnt;
   logic [IDX_W-1:0] ref_idx;
   logic [TAG_W-1:0] ref_tag;

   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             tag_match;
   logic             load;
   logic             hit;
   logic             last_word;

   assign offset    = addr[OFF_W+1:2];
   assign index     = addr[OFF_W+2 +: IDX_W];
   assign tag       = addr[WD-1 -: TAG_W];
   assign tag_match = valid[index] && (tag_arr[index] == tag);
   assign load      = rd_en && !wr_en;
   assign hit       = load && tag_match;
   assign rdata     = hit ? data_arr[index][offset] : '0;
   assign last_word = (cnt == OFF_W'(WORDS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      case (state)
         IDLE: begin
            if (wr_en) begin
               stall    = 1'b1;
               state_nx = WRITE;
            end else if (rd_en && !hit) begin
               stall    = 1'b1;
               state_nx = REFILL;
            end
         end
         REFILL: begin
            stall = 1'b1;
            if (mem_ready && last_word) state_nx = IDLE;
         end
         WRITE: begin
            stall = !mem_ready;
            if (mem_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // A held load/store during reset must not freeze the core.
      if (!rst) stall = 1'b0;
   end

   // Control, valid bits and the memory-side request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid     <= '0;
         cnt       <= '0;
         ref_idx   <= '0;
         ref_tag   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr & ~WD'(3);
                  mem_wdata <= wdata;
               end else if (rd_en && !hit) begin
                  // The line is invalid until its last word lands, so a
                  // half-written victim can never produce a false hit.
                  valid[index] <= 1'b0;
                  cnt          <= '0;
                  ref_idx      <= index;
                  ref_tag      <= tag;
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_addr     <= addr & ~WD'(WORDS * 4 - 1);
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + WD'(4);
                  if (last_word) begin
                     valid[ref_idx] <= 1'b1;
                     mem_req        <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data storage carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (rst && state == IDLE && wr_en && tag_match)
         data_arr[index][offset] <= wdata;
      if (rst && state == REFILL && mem_ready) begin
         data_arr[ref_idx][cnt] <= mem_rdata;
         if (last_word) tag_arr[ref_idx] <= ref_tag;
      end
   end

endmodule
